// File: rtl/unpack_8b1b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : unpack_8b1b
// Function : Serializes whole bytes into single-bit words, MSB first, through
//            a two-entry (shift + hold) byte buffer.
// Revision : 1.0 - initial release
// ============================================================================
module unpack_8b1b #(
    parameter bit UNPACK_ENABLE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din_i,
    input  logic       we_i,
    output logic       full_o,
    output logic [7:0] dout_o,
    output logic       en_o,
    input  logic       re_i,
    output logic       ovf_o
);

    logic [7:0] sh_q, sh_d;
    logic [7:0] hd_q, hd_d;
    logic       sh_v_q, sh_v_d;
    logic       hd_v_q, hd_v_d;
    logic [2:0] cnt_q, cnt_d;
    logic       ovf_q, ovf_d;

    logic       w_full;
    logic       w_accept;
    logic       w_pop;
    logic       w_last;

    assign w_full   = sh_v_q & hd_v_q;
    assign w_accept = we_i & ~w_full;
    assign w_pop    = sh_v_q & re_i;
    assign w_last   = w_pop & (cnt_q == 3'd7);

    always_comb begin
        sh_d   = sh_q;
        hd_d   = hd_q;
        sh_v_d = sh_v_q;
        hd_v_d = hd_v_q;
        cnt_d  = cnt_q;
        ovf_d  = ovf_q;

        if (w_pop) begin
            if (!w_last) begin
                sh_d  = {sh_q[6:0], 1'b0};
                cnt_d = cnt_q + 3'd1;
            end else begin
                cnt_d = 3'd0;
                if (hd_v_q) begin
                    sh_d   = hd_q;
                    hd_v_d = 1'b0;
                end else if (w_accept) begin
                    // Incoming byte bypasses the empty hold register.
                    sh_d = din_i;
                end else begin
                    sh_d   = {sh_q[6:0], 1'b0};
                    sh_v_d = 1'b0;
                end
            end
        end

        if (w_accept) begin
            if (!sh_v_q) begin
                sh_d   = din_i;
                sh_v_d = 1'b1;
                cnt_d  = 3'd0;
            end else if (!w_last) begin
                hd_d   = din_i;
                hd_v_d = 1'b1;
            end
        end

        if (we_i && w_full) begin
            ovf_d = 1'b1;
        end
    end

    // In pass-through mode the registers never leave their reset values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q   <= 8'd0;
            hd_q   <= 8'd0;
            sh_v_q <= 1'b0;
            hd_v_q <= 1'b0;
            cnt_q  <= 3'd0;
            ovf_q  <= 1'b0;
        end else if (UNPACK_ENABLE) begin
            sh_q   <= sh_d;
            hd_q   <= hd_d;
            sh_v_q <= sh_v_d;
            hd_v_q <= hd_v_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
        end
    end

    generate
        if (UNPACK_ENABLE) begin : g_serialize
            assign en_o   = sh_v_q;
            assign dout_o = {7'd0, sh_q[7]};
            assign full_o = w_full;
            assign ovf_o  = ovf_q;
        end else begin : g_passthru
            assign en_o   = we_i;
            assign dout_o = din_i;
            assign full_o = 1'b0;
            assign ovf_o  = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_unpack_8b1b.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_unpack_8b1b
// Function : Self-checking bench for unpack_8b1b (directed + random vs model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_unpack_8b1b;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] din;
    logic       we;
    logic       re;
    logic       full;
    logic [7:0] dout;
    logic       en;
    logic       ovf;

    logic [7:0] pt_din;
    logic       pt_we;
    logic       pt_re;
    logic       pt_full;
    logic [7:0] pt_dout;
    logic       pt_en;
    logic       pt_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    unpack_8b1b #(.UNPACK_ENABLE(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .din_i (din),
        .we_i  (we),
        .full_o(full),
        .dout_o(dout),
        .en_o  (en),
        .re_i  (re),
        .ovf_o (ovf)
    );

    unpack_8b1b #(.UNPACK_ENABLE(1'b0)) dut_pt (
        .clk   (clk),
        .rst_n (rst_n),
        .din_i (pt_din),
        .we_i  (pt_we),
        .full_o(pt_full),
        .dout_o(pt_dout),
        .en_o  (pt_en),
        .re_i  (pt_re),
        .ovf_o (pt_ovf)
    );

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       re;
        logic       exp_en;
        logic       exp_bit;
        logic       exp_full;
        logic       exp_ovf;
    } vec_t;

    // Reference model: queue of buffered bytes plus index of the current bit.
    logic [7:0] mq[$];
    int         midx;
    logic       movf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        we    = 1'b0;
        re    = 1'b0;
        din   = 8'd0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic m_step(input logic m_we, input logic [7:0] m_din, input logic m_re);
        logic m_full;
        m_full = (mq.size() == 2);
        if (mq.size() > 0 && m_re) begin
            midx++;
            if (midx == 8) begin
                void'(mq.pop_front());
                midx = 0;
            end
        end
        if (m_we && m_full) movf = 1'b1;
        else if (m_we) mq.push_back(m_din);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t       tbl[10];
        logic [15:0] pat;
        logic [7:0]  acc;
        int          sent, got, nb, cyc;
        logic        started, gap;
        logic        m_en, m_full;
        logic [7:0]  m_dout;

        pt_din = 8'd0; pt_we = 1'b0; pt_re = 1'b0;

        tbl[0] = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // Reset state
        do_reset();
        chk("rst_en", en, 0);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dout", dout, 0);

        // Single byte 0xA5, table driven
        for (int i = 0; i < 10; i++) begin
            we  = tbl[i].we;
            din = tbl[i].din;
            re  = tbl[i].re;
            chk("a5_en", en, tbl[i].exp_en);
            chk("a5_full", full, tbl[i].exp_full);
            chk("a5_ovf", ovf, tbl[i].exp_ovf);
            if (tbl[i].exp_en) chk("a5_dout", dout, {7'd0, tbl[i].exp_bit});
            tick();
        end

        // Round trip through a packer model
        do_reset();
        sent = 0; got = 0; nb = 0; cyc = 0; acc = 8'd0; started = 1'b0; gap = 1'b0;
        while (got < 256 && cyc < 5000) begin
            we  = !full && (sent < 256);
            din = sent[7:0];
            re  = 1'b1;
            if (en) begin
                started = 1'b1;
                acc = {acc[6:0], dout[0]};
                nb++;
                if (nb == 8) begin
                    chk("rt_byte", acc, got);
                    got++;
                    nb = 0;
                end
            end else if (started) begin
                gap = 1'b1;
            end
            if (we) sent++;
            tick();
            cyc++;
        end
        we = 1'b0;
        chk("rt_count", got, 256);
        chk("rt_gap", gap, 0);
        chk("rt_ovf", ovf, 0);

        // Backpressure and overflow
        do_reset();
        re = 1'b0; we = 1'b1; din = 8'hFF;
        tick();
        din = 8'h00;
        tick();
        chk("bp_full", full, 1);
        chk("bp_ovf0", ovf, 0);
        din = 8'h3C;
        tick();
        we = 1'b0;
        chk("bp_ovf1", ovf, 1);
        chk("bp_full2", full, 1);
        re = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("bp_en", en, 1);
            chk("bp_bit", dout, (i < 8) ? 1 : 0);
            tick();
        end
        chk("bp_end_en", en, 0);
        chk("bp_sticky", ovf, 1);

        // Write colliding with last-bit pop
        do_reset();
        we = 1'b1; din = 8'h80; re = 1'b0;
        tick();
        re  = 1'b1;
        pat = 16'h8001;
        for (int i = 0; i < 16; i++) begin
            we  = (i == 7);
            din = 8'h01;
            chk("col_en", en, 1);
            chk("col_bit", dout, {7'd0, pat[15-i]});
            chk("col_full", full, 0);
            tick();
        end
        we = 1'b0;
        chk("col_end_en", en, 0);

        // Asynchronous reset mid-byte with full buffer and overflow set
        re = 1'b0; we = 1'b1; din = 8'hF0;
        tick();
        din = 8'hAA;
        tick();
        din = 8'h55;
        tick();
        we = 1'b0; re = 1'b1;
        tick();
        tick();
        tick();
        chk("ar_pre_full", full, 1);
        chk("ar_pre_ovf", ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_en", en, 0);
        chk("ar_full", full, 0);
        chk("ar_ovf", ovf, 0);
        chk("ar_dout", dout, 0);
        re = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("ar_rel_en", en, 0);
        we = 1'b1; din = 8'h0F; re = 1'b1;
        tick();
        we = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("ar_en2", en, 1);
            chk("ar_bit", dout, (i < 4) ? 0 : 1);
            tick();
        end
        chk("ar_end_en", en, 0);

        // Pass-through instance
        pt_din = 8'h5A; pt_we = 1'b1; pt_re = 1'b0;
        #1;
        chk("pt_dout", pt_dout, 8'h5A);
        chk("pt_en", pt_en, 1);
        chk("pt_full", pt_full, 0);
        pt_re = 1'b1;
        #1;
        chk("pt_dout_re", pt_dout, 8'h5A);
        chk("pt_full_re", pt_full, 0);
        tick();
        chk("pt_ovf", pt_ovf, 0);
        pt_we = 1'b0; pt_din = 8'hC3;
        #1;
        chk("pt_en0", pt_en, 0);
        chk("pt_dout2", pt_dout, 8'hC3);

        // Random stimulus vs reference model
        do_reset();
        mq.delete();
        midx = 0;
        movf = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            we  = ($urandom_range(0, 7) < ((c < 1500) ? 1 : 3));
            din = 8'($urandom);
            re  = ($urandom_range(0, 7) < 6);
            m_en   = (mq.size() > 0);
            m_full = (mq.size() == 2);
            chk("rnd_flags", {en, full, ovf}, {m_en, m_full, movf});
            if (m_en) begin
                m_dout = {7'd0, mq[0][7-midx]};
                chk("rnd_dout", dout, m_dout);
            end
            m_step(we, din, re);
            tick();
        end
        we = 1'b0;
        re = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/unpack_8b1b.md
Name: unpack_8b1b

Overview:
- Inverse of the 1b-to-8b packer: accepts whole bytes and serializes each into 8 single-bit words, MSB first.
- Bit order is chosen so that packer(unpack_8b1b(x)) == x.
- Sits between a byte source (UART RX / host FIFO) and any stage consuming one random bit per word, e.g. a replayed-bitstream test path into post-processing.
- Two-entry byte buffer (shift + hold) sustains back-to-back bytes without bubbles.

Parameters:
- UNPACK_ENABLE, 1'b1, 1 = serialize; 0 = pass-through (DOUT=DIN, EN=WE, FULL=0, RE ignored).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  reset, asynchronous, active-low (0 = reset).
- DIN  in  8  byte to serialize.
- WE   in  1  byte write strobe; accepted when WE & !FULL.
- FULL  out  1  buffer full; a write in this cycle is dropped.
- DOUT  out  8  output word; bit in DOUT[0], DOUT[7:1]=0 in serialize mode.
- EN  out  1  DOUT valid.
- RE  in  1  consumer takes current bit; a transfer occurs when EN & RE.
- OVF  out  1  sticky overflow: a write was dropped.

Behaviour:
- State: sh[7:0] shift reg, sh_v; hd[7:0] hold reg, hd_v; cnt[2:0] bits already emitted from sh; ovf.
- Reset (RST=0, async, any time incl. mid-byte): sh=hd=0, sh_v=hd_v=0, cnt=0, ovf=0.
  - Outputs: EN=0, FULL=0, DOUT=0, OVF=0.
  - Partially emitted bytes are discarded. Exit from reset is synchronous to next CLK edge.
- Outputs (combinational from registers only, no DIN/RE paths in serialize mode):
  - EN = sh_v.
  - DOUT = {7'b0, sh[7]}.
  - FULL = sh_v & hd_v.
  - OVF = ovf.
- Pop (EN & RE):
  - cnt<7: sh<=sh<<1, cnt<=cnt+1.
  - cnt==7 (last bit):
    - hd_v: sh<=hd, hd_v<=0, cnt<=0.
    - else if accepted write this cycle: sh<=DIN, cnt<=0.
    - else: sh_v<=0, cnt<=0.
- Write accept (WE & !FULL), with priority on same-cycle events:
  - sh_v=0: sh<=DIN, sh_v<=1, cnt<=0. First bit DIN[7] visible on DOUT next cycle (latency 1).
  - sh_v=1, hd_v=0, no last-bit pop: hd<=DIN, hd_v<=1.
  - sh_v=1, hd_v=0, last-bit pop same cycle: DIN loads straight into sh; hd stays empty.
  - sh_v=1, hd_v=1 (FULL): write dropped even if a last-bit pop happens the same cycle. ovf<=1. Buffers unchanged except for the pop.
- ovf clears only on reset.
- Throughput: with RE held 1 and a write every 8 cycles, EN stays 1 continuously; one bit per cycle.
- RE while EN=0: no effect.
- UNPACK_ENABLE=0: registers held at reset values; outputs combinational pass-through. OVF=0.

Test Plan:
- Reset then single write DIN=8'hA5, RE=1 constant -> EN high 8 cycles starting cycle after write, DOUT[0] sequence 1,0,1,0,0,1,0,1. Then EN=0, FULL never 1.
- Round trip: 256 bytes 0x00..0xFF written whenever !FULL, unpacker output fed to the 1b8b packer (WE=EN, RE=1) -> packer emits identical 256 bytes. EN continuous after first, OVF=0.
- Backpressure: write 8'hFF, 8'h00 with RE=0 -> FULL=1 after second write. Third write 8'h3C dropped, OVF=1. Releasing RE -> eight 1s, then eight 0s, no 0x3C bits.
- Last-bit collision: sh holds 8'h80 at cnt=7, hd empty, RE=1 and WE with DIN=8'h01 same cycle -> next cycle EN=1, DOUT[0]=0, cnt=0. The eighth bit of that byte is 1.
- Async reset mid-byte: write 8'hF0, pop 3 bits, drop RST=0 between clock edges -> EN, FULL, OVF, DOUT go 0 immediately without a clock edge. After release, a new write 8'h0F yields 0,0,0,0,1,1,1,1.
- UNPACK_ENABLE=0: DIN=8'h5A, WE=1 -> same cycle DOUT=8'h5A, EN=1, FULL=0 regardless of RE.
